hazard_stall_unit: RTL

- Feedback end of the ID/EX pipeline-register interface. It decides each cycle whether the ID/EX register captures the decoded instruction or a bubble.
- It also drives the PC, IF/ID, and ID/EX enable and flush controls.
- It keeps an internal scoreboard that shadows the destination registers and flag writers in EX, MEM and WB, so it can detect RAW and flag hazards.
- It counts stall and flush events for performance debug.

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/hazard_stall_unit_sat_counter.sv | 33 +++
 rtl/hazard_stall_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared scoreboard entry, forward-select encoding and register-index constants
package pipe_pkg;

  // Register-index width carried in a scoreboard entry.
  localparam int REG_IDX_W = 5;

  // Register index that never creates a hazard (XZR).
  localparam int ZERO_REG = 31;

  // Scoreboard stage slots.
  localparam int SB_EX    = 0;
  localparam int SB_MEM   = 1;
  localparam int SB_WB    = 2;
  localparam int SB_DEPTH = 3;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 is_load;
    logic                 flag_write;
  } sb_entry_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  // A source read by ID collides with an older in-flight destination.
  function automatic logic raw_match(input sb_entry_t e, input logic used,
                                     input logic [REG_IDX_W-1:0] src);
    return e.valid && used && (src == e.rd);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// rtl/hazard_stall_unit_sat_counter.sv - saturating event counter, holds at all-ones
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Step by one unless already pinned at the maximum.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register, cleared immediately on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - ID/EX stall/flush control with RAW/flag scoreboard; HAZARD_FWD_EN enables forwarding
module hazard_stall_unit
  import pipe_pkg::sb_entry_t, pipe_pkg::fwd_sel_t, pipe_pkg::raw_match,
         pipe_pkg::FWD_RF, pipe_pkg::FWD_EXMEM, pipe_pkg::FWD_MEMWB,
         pipe_pkg::SB_EX, pipe_pkg::SB_MEM, pipe_pkg::SB_WB, pipe_pkg::SB_DEPTH;
#(
  parameter int NREG_W   = pipe_pkg::REG_IDX_W,
  parameter int ZERO_REG = pipe_pkg::ZERO_REG,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREG_W-1:0] id_rn,
  input  logic [NREG_W-1:0] id_rm,
  input  logic              id_uses_rn,
  input  logic              id_uses_rm,
  input  logic [NREG_W-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_flag_write,
  input  logic              id_reads_flags,
  input  logic              mem_take_branch,
  output logic              pc_enable,
  output logic              if_id_enable,
  output logic              if_id_flush,
  output logic              id_ex_enable,
  output logic              id_ex_bubble,
  output logic              ex_mem_flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam logic [NREG_W-1:0] ZERO_IDX = ZERO_REG[NREG_W-1:0];

  sb_entry_t sb_q [SB_DEPTH];
  sb_entry_t sb_d [SB_DEPTH];
  sb_entry_t id_entry;

  logic raw_ex_a;
  logic raw_ex_b;
  logic raw_mem_a;
  logic raw_mem_b;
  logic flag_haz;
  logic stall;
  logic flush;
  logic issue;

  // Hazard detection against the in-flight scoreboard; WB never stalls (write-before-read RF).
  always_comb begin
    raw_ex_a  = raw_match(sb_q[SB_EX],  id_uses_rn, id_rn);
    raw_ex_b  = raw_match(sb_q[SB_EX],  id_uses_rm, id_rm);
    raw_mem_a = raw_match(sb_q[SB_MEM], id_uses_rn, id_rn);
    raw_mem_b = raw_match(sb_q[SB_MEM], id_uses_rm, id_rm);
    flag_haz  = id_reads_flags & sb_q[SB_EX].flag_write;
    flush     = mem_take_branch;
`ifdef HAZARD_FWD_EN
    stall     = ((raw_ex_a | raw_ex_b) & sb_q[SB_EX].is_load) | flag_haz;
`else
    stall     = raw_ex_a | raw_ex_b | raw_mem_a | raw_mem_b | flag_haz;
`endif
    issue     = ~stall & ~flush;
  end

  // Scoreboard advance; a flush squashes the wrong-path EX entry instead of promoting it.
  always_comb begin
    id_entry            = '0;
    id_entry.valid      = id_reg_write && (id_rd != ZERO_IDX);
    id_entry.rd         = id_rd;
    id_entry.is_load    = id_mem_read;
    id_entry.flag_write = id_flag_write;
    sb_d[SB_WB]         = sb_q[SB_MEM];
    sb_d[SB_MEM]        = flush ? '0 : sb_q[SB_EX];
    sb_d[SB_EX]         = issue ? id_entry : '0;
  end

  // Scoreboard registers, emptied immediately on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_q[i] <= sb_d[i];
      end
    end
  end

  assign pc_enable    = ~stall | flush;
  assign if_id_enable = ~stall | flush;
  assign id_ex_enable = 1'b1;
  assign id_ex_bubble = stall | flush;
  assign if_id_flush  = flush;
  assign ex_mem_flush = flush;

`ifdef HAZARD_FWD_EN
  fwd_sel_t fwd_a;
  fwd_sel_t fwd_b;

  // Forward selects for the issuing instruction; the youngest (EX) producer wins.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (raw_ex_a) begin
      fwd_a = FWD_EXMEM;
    end else if (raw_mem_a) begin
      fwd_a = FWD_MEMWB;
    end
    if (raw_ex_b) begin
      fwd_b = FWD_EXMEM;
    end else if (raw_mem_b) begin
      fwd_b = FWD_MEMWB;
    end
  end

  assign fwd_a_sel = fwd_a;
  assign fwd_b_sel = fwd_b;
`else
  assign fwd_a_sel = 2'b00;
  assign fwd_b_sel = 2'b00;
`endif

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall & ~flush),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush),
    .count (flush_count)
  );

endmodule
